// File: rtl/seq_signed_mult.sv
// seq_signed_mult: iterative shift-add multiplier, one multiplier bit per clock.
// tc=1 runs the operands through a sign/magnitude path so they can be signed;
// tc=0 treats them as unsigned.
// Optional feature: define SEQ_MULT_ZERO_SKIP_EN to finish zero-operand jobs on
// the accept edge instead of running all B_WIDTH iterations.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE, and both
// come straight from the state register. A producer holds in_valid and its data
// stable until the transfer. The block holds out_valid and product stable while
// out_ready is low.
module seq_signed_mult #(
   parameter int A_WIDTH       = 8,
   parameter int B_WIDTH       = 8,
   parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [A_WIDTH-1:0]       dat_a,
   input  logic [B_WIDTH-1:0]       dat_b,
   input  logic                     tc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PRODUCT_WIDTH-1:0] product,
   output logic [1:0]               dbg_state
);

   localparam int CNT_W = $clog2(B_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic                     accept;
   logic                     last_iter;
   logic                     zero_op;
   logic [A_WIDTH-1:0]       mag_a_in;
   logic [B_WIDTH-1:0]       mag_b_in;
   logic [PRODUCT_WIDTH-1:0] mcand;    // multiplicand magnitude at the current bit weight
   logic [B_WIDTH-1:0]       mplier;   // remaining multiplier bits, LSB is the next one
   logic [PRODUCT_WIDTH-1:0] acc;
   logic [PRODUCT_WIDTH-1:0] acc_sum;
   logic                     sign;
   logic [CNT_W-1:0]         cnt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;
   assign accept    = in_valid & in_ready;
   assign last_iter = (cnt == CNT_W'(B_WIDTH - 1));

   // Magnitudes are kept unsigned, so the most-negative operand stays 2^(W-1).
   assign mag_a_in = (tc && dat_a[A_WIDTH-1]) ? -dat_a : dat_a;
   assign mag_b_in = (tc && dat_b[B_WIDTH-1]) ? -dat_b : dat_b;
   assign acc_sum  = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_ZERO_SKIP_EN
   assign zero_op = (dat_a == '0) || (dat_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = zero_op ? DONE : CALC;
         CALC:    if (last_iter) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, one shift-add step per CALC edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         sign    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= PRODUCT_WIDTH'(mag_a_in);
                  mplier <= mag_b_in;
                  sign   <= tc & (dat_a[A_WIDTH-1] ^ dat_b[B_WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
                  if (zero_op) product <= '0;
               end
            end
            CALC: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last_iter) product <= sign ? -acc_sum : acc_sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_mult.sv
// tb_seq_signed_mult: directed and random checks of seq_signed_mult (8x8).
// The reference is plain integer multiplication truncated to 16 bits.
module tb_seq_signed_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  dat_a;
   logic [7:0]  dat_b;
   logic        tc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q[$];

   seq_signed_mult #(.A_WIDTH(8), .B_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dat_a     (dat_a),
      .dat_b     (dat_b),
      .tc        (tc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .dbg_state (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic t);
      longint av;
      longint bv;
      av = t ? longint'($signed(a)) : longint'(a);
      bv = t ? longint'($signed(b)) : longint'(b);
      return 16'(av * bv);
   endfunction

   function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
      return (a == 8'h00 || b == 8'h00) ? 0 : 8;
`else
      return 8 + 0 * int'(a) * int'(b);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Scoreboard: every cycle the product is offered it must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_out_valid");
         end else begin
            check("product_vs_model", 32'(product), 32'(exp_q[0]));
            check("in_ready_low_in_done", 32'(in_ready), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Present operands and wait for the accept edge
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic t);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("wait_in_ready");
      dat_a    = a;
      dat_b    = b;
      tc       = t;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(a, b, t));
      #1;
      in_valid = 1'b0;
      dat_a    = 8'($urandom_range(0, 255));
      dat_b    = 8'($urandom_range(0, 255));
      tc       = 1'($urandom_range(0, 1));
   endtask

   // Count edges after the accept edge until out_valid is seen
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) timeout("wait_out_valid");
   endtask

   task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic t, input logic [15:0] exp);
      int lat;
      check("model_pin", 32'(model(a, b, t)), 32'(exp));
      issue(a, b, t);
      wait_valid(lat);
      check("latency", 32'(lat), 32'(exp_latency(a, b)));
      check("product_literal", 32'(product), 32'(exp));
   endtask

   task automatic drain_random();
      bit done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) done = 1;
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (done) break;
      end
      if (!done) timeout("drain_handshake");
   endtask

   function automatic logic [7:0] pick_operand();
      logic [7:0] corners[4] = '{8'h00, 8'h80, 8'h7F, 8'hFF};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
      return 8'($urandom_range(0, 255));
   endfunction

   // Main sequence
   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      dat_a     = 8'h00;
      dat_b     = 8'h00;
      tc        = 1'b0;
      out_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_product", 32'(product), 32'd0);
      rst_n = 1'b1;

      // Directed vectors; the first one is accepted on the first edge after release
      directed(8'hFD, 8'h05, 1'b1, 16'hFFF1);
      directed(8'hFD, 8'h05, 1'b0, 16'h04F1);
      directed(8'h80, 8'h80, 1'b1, 16'h4000);
      directed(8'h80, 8'h7F, 1'b1, 16'hC080);
      directed(8'h7F, 8'h80, 1'b1, 16'hC080);
      directed(8'hFF, 8'hFF, 1'b1, 16'h0001);
      directed(8'hFF, 8'hFF, 1'b0, 16'hFE01);
      directed(8'h01, 8'hFF, 1'b1, 16'hFFFF);
      directed(8'h00, 8'h5A, 1'b0, 16'h0000);
      directed(8'h5A, 8'h00, 1'b1, 16'h0000);

      // Backpressure, with a spurious in_valid pulse during CALC
      @(negedge clk);
      out_ready = 1'b0;
      issue(8'h9C, 8'h3B, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dat_a    = 8'h11;
      dat_b    = 8'h22;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_product", 32'(product), 32'hE8F4);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      check("bp_product_retained", 32'(product), 32'hE8F4);
      repeat (12) @(negedge clk);
      check("bp_pulse_ignored", 32'(out_valid), 32'd0);

      // Reset in the middle of CALC
      issue(8'h33, 8'h44, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_product", 32'(product), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("midrst_no_stale_valid", 32'(out_valid), 32'd0);
      directed(8'h07, 8'h06, 1'b0, 16'h002A);

      // Random sweep with random output stalls
      for (int n = 0; n < 400; n++) begin
         issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
         drain_random();
      end
      out_ready = 1'b1;
      repeat (20) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
